// File: rtl/debug_display.sv
`default_nettype none
// ============================================================================
// Module      : debug_display
// Description : Board-level viewer for the processor's observation outputs.
//               Two debounced buttons pick one of seven 32-bit sources and
//               its upper or lower 16 bits. The selected half is shown as
//               four hex digits on a multiplexed, active-low 7-segment
//               display.
// Config      : Define LEADING_ZERO_BLANK_EN to blank the digits above the
//               most-significant nonzero nibble. Digit 0 is always lit.
//               When the macro is undefined, all four digits are shown.
// Ports       : clk            in   system clock, rising edge
//               resetN         in   asynchronous active-low reset
//               btnSelect      in   raw button, advances the source select
//               btnHalf        in   raw button, toggles the upper/lower half
//               programCounter in   source 0
//               aluResult      in   source 1
//               r1,r2,r5,r7    in   sources 2,3,4,5
//               mem25          in   source 6
//               an[3:0]        out  digit anodes, active-low, an[0] rightmost
//               seg[6:0]       out  segments {g,f,e,d,c,b,a}, active-low
//               dp             out  decimal point, active-low
//               ledSel[2:0]    out  current source index
// Revision    : 1.0  initial release
// ============================================================================
module debug_display #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        btnSelect,
    input  logic        btnHalf,
    input  logic [31:0] programCounter,
    input  logic [31:0] aluResult,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] r5,
    input  logic [31:0] r7,
    input  logic [31:0] mem25,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  ledSel
);

    localparam int c_DB_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RF_WIDTH = $clog2(REFRESH_CYCLES + 1);
    localparam logic [c_DB_WIDTH-1:0] c_DB_LAST = c_DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_WIDTH-1:0] c_DB_ONE  = c_DB_WIDTH'(1);
    localparam logic [c_RF_WIDTH-1:0] c_RF_LAST = c_RF_WIDTH'(REFRESH_CYCLES - 1);
    localparam logic [c_RF_WIDTH-1:0] c_RF_ONE  = c_RF_WIDTH'(1);
    localparam logic [2:0]            c_SEL_LAST = 3'd6;

    // Index 0 = select button, index 1 = half button.
    logic [1:0] w_rawBtn;
    logic [1:0] w_btnPulse;

    assign w_rawBtn = {btnHalf, btnSelect};

    // ------------------------------------------------------------------------
    // Per-button synchronizer + debouncer. The counter counts consecutive
    // synced samples that differ from the accepted level. The level flips on
    // the DEBOUNCE_CYCLES-th such sample. Only a rising flip emits a pulse.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic [1:0]            r_sync;
            logic                  r_level;
            logic                  r_pulse;
            logic [c_DB_WIDTH-1:0] r_count;

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    r_sync  <= 2'b00;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                    r_count <= '0;
                end else begin
                    r_sync  <= {r_sync[0], w_rawBtn[gi]};
                    r_pulse <= 1'b0;
                    if (r_sync[1] == r_level) begin
                        r_count <= '0;
                    end else if (r_count == c_DB_LAST) begin
                        r_count <= '0;
                        r_level <= r_sync[1];
                        r_pulse <= r_sync[1];
                    end else begin
                        r_count <= r_count + c_DB_ONE;
                    end
                end
            end

            assign w_btnPulse[gi] = r_pulse;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Source / half selection. The select button wins over the half button
    // and always returns to the lower half.
    // ------------------------------------------------------------------------
    logic [2:0] r_sel;
    logic       r_half;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sel  <= 3'd0;
            r_half <= 1'b0;
        end else if (w_btnPulse[0]) begin
            r_sel  <= (r_sel == c_SEL_LAST) ? 3'd0 : r_sel + 3'd1;
            r_half <= 1'b0;
        end else if (w_btnPulse[1]) begin
            r_half <= ~r_half;
        end
    end

    assign ledSel = r_sel;

    logic [31:0] w_source;
    logic [15:0] w_taken;

    always_comb begin
        w_source = programCounter;
        case (r_sel)
            3'd0:    w_source = programCounter;
            3'd1:    w_source = aluResult;
            3'd2:    w_source = r1;
            3'd3:    w_source = r2;
            3'd4:    w_source = r5;
            3'd5:    w_source = r7;
            3'd6:    w_source = mem25;
            default: w_source = programCounter;
        endcase
        w_taken = r_half ? w_source[31:16] : w_source[15:0];
    end

    // ------------------------------------------------------------------------
    // Scan timing. The snapshot is refreshed only on the 3 -> 0 wrap, so one
    // frame always shows a single coherent value.
    // ------------------------------------------------------------------------
    logic [c_RF_WIDTH-1:0] r_refresh;
    logic [1:0]            r_digit;
    logic [15:0]           r_snapshot;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_refresh  <= '0;
            r_digit    <= 2'd0;
            r_snapshot <= 16'h0000;
        end else if (r_refresh == c_RF_LAST) begin
            r_refresh <= '0;
            r_digit   <= r_digit + 2'd1;
            if (r_digit == 2'd3) begin
                r_snapshot <= w_taken;
            end
        end else begin
            r_refresh <= r_refresh + c_RF_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Digit decode.
    // ------------------------------------------------------------------------
    logic [3:0] w_nibble;
    logic [6:0] w_segCode;
    logic       w_blank;

    assign w_nibble = r_snapshot[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_segCode = 7'b1000000;
        case (w_nibble)
            4'h0: w_segCode = 7'b1000000;
            4'h1: w_segCode = 7'b1111001;
            4'h2: w_segCode = 7'b0100100;
            4'h3: w_segCode = 7'b0110000;
            4'h4: w_segCode = 7'b0011001;
            4'h5: w_segCode = 7'b0010010;
            4'h6: w_segCode = 7'b0000010;
            4'h7: w_segCode = 7'b1111000;
            4'h8: w_segCode = 7'b0000000;
            4'h9: w_segCode = 7'b0010000;
            4'hA: w_segCode = 7'b0001000;
            4'hB: w_segCode = 7'b0000011;
            4'hC: w_segCode = 7'b1000110;
            4'hD: w_segCode = 7'b0100001;
            4'hE: w_segCode = 7'b0000110;
            4'hF: w_segCode = 7'b0001110;
            default: w_segCode = 7'b1000000;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Highest digit that must stay lit. Later tests override earlier ones,
    // so the result is the most-significant nonzero nibble (or digit 0).
    logic [1:0] w_topDigit;

    always_comb begin
        w_topDigit = 2'd0;
        if (r_snapshot[7:4]   != 4'h0) w_topDigit = 2'd1;
        if (r_snapshot[11:8]  != 4'h0) w_topDigit = 2'd2;
        if (r_snapshot[15:12] != 4'h0) w_topDigit = 2'd3;
    end

    assign w_blank = (r_digit > w_topDigit);
`else
    assign w_blank = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Registered display outputs. an, seg and dp all follow r_digit by one
    // cycle, so they change together.
    // ------------------------------------------------------------------------
    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_digit);
            r_seg <= w_blank ? 7'h7F : w_segCode;
            r_dp  <= ~((r_digit == 2'd3) & r_half);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_debug_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_display
// Description : Directed self-checking bench for debug_display, using short
//               debounce (4) and refresh (8) periods. Honours
//               LEADING_ZERO_BLANK_EN when it is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_debug_display;

    logic        clk = 1'b0;
    logic        resetN;
    logic        btnSelect;
    logic        btnHalf;
    logic [31:0] programCounter;
    logic [31:0] aluResult;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r5;
    logic [31:0] r7;
    logic [31:0] mem25;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  ledSel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_display #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .btnSelect     (btnSelect),
        .btnHalf       (btnHalf),
        .programCounter(programCounter),
        .aluResult     (aluResult),
        .r1            (r1),
        .r2            (r2),
        .r5            (r5),
        .r7            (r7),
        .mem25         (mem25),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .ledSel        (ledSel)
    );

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press and release: 8 cycles high covers sync + debounce + pulse,
    // and 8 cycles low lets the release debounce settle.
    task automatic press(input logic s, input logic h);
        btnSelect = s;
        btnHalf   = h;
        repeat (8) @(negedge clk);
        btnSelect = 1'b0;
        btnHalf   = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Stops on the first negedge where digit 0 becomes lit after another digit.
    task automatic waitFrameStart(input string tag);
        int n = 0;
        bit seenOther = 1'b0;
        bit found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (an !== 4'b1110) seenOther = 1'b1;
            else if (seenOther) found = 1'b1;
        end
        chk({tag, "_frameStart"}, {31'd0, found}, 32'd1);
    endtask

    task automatic checkFrame(input logic [15:0] val, input logic hb, input string tag);
        int top = 3;
`ifdef LEADING_ZERO_BLANK_EN
        top = 0;
        for (int k = 1; k < 4; k++) begin
            if (val[4*k +: 4] != 4'h0) top = k;
        end
`endif
        waitFrameStart(tag);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] expAn;
            logic [6:0] expSeg;
            logic       expDp;
            if (d > 0) repeat (8) @(negedge clk);
            if (d > top) begin
                expAn  = 4'b1111;
                expSeg = 7'h7F;
            end else begin
                expAn  = ~(4'b0001 << d);
                expSeg = hexSeg(val[4*d +: 4]);
            end
            expDp = (d == 3 && hb) ? 1'b0 : 1'b1;
            chk($sformatf("%s_an%0d", tag, d),  {28'd0, an},  {28'd0, expAn});
            chk($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, expSeg});
            chk($sformatf("%s_dp%0d", tag, d),  {31'd0, dp},  {31'd0, expDp});
        end
    endtask

    initial begin
        int changes;
        logic [2:0] prevSel;

        resetN         = 1'b1;
        btnSelect      = 1'b0;
        btnHalf        = 1'b0;
        programCounter = 32'h89AB_0765;
        aluResult      = 32'h5555_C3E0;
        r1             = 32'h1234_ABCD;
        r2             = 32'h2222_3333;
        r5             = 32'h5555_6666;
        r7             = 32'h7777_8888;
        mem25          = 32'h9999_AAAA;

        // Reset values
        #2 resetN = 1'b0;
        #1;
        chk("rst_an",     {28'd0, an},     32'h0000_000E);
        chk("rst_seg",    {25'd0, seg},    32'h0000_0040);
        chk("rst_dp",     {31'd0, dp},     32'd1);
        chk("rst_ledSel", {29'd0, ledSel}, 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        // Glitch shorter than the debounce window is ignored
        btnSelect = 1'b1;
        repeat (3) @(negedge clk);
        btnSelect = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_ledSel", {29'd0, ledSel}, 32'd0);

        // A long hold advances exactly once, release does nothing
        changes = 0;
        prevSel = ledSel;
        btnSelect = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) btnSelect = 1'b0;
            @(negedge clk);
            if (ledSel !== prevSel) changes++;
            prevSel = ledSel;
        end
        chk("hold_changes", changes, 32'd1);
        chk("hold_ledSel", {29'd0, ledSel}, 32'd1);

        // r1 lower then upper half
        press(1'b1, 1'b0);
        chk("r1_ledSel", {29'd0, ledSel}, 32'd2);
        checkFrame(16'hABCD, 1'b0, "r1lo");
        press(1'b0, 1'b1);
        checkFrame(16'h1234, 1'b1, "r1hi");

        // Asynchronous reset in the middle of digit 3
        repeat (3) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("midrst_an",     {28'd0, an},     32'h0000_000E);
        chk("midrst_seg",    {25'd0, seg},    32'h0000_0040);
        chk("midrst_dp",     {31'd0, dp},     32'd1);
        chk("midrst_ledSel", {29'd0, ledSel}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        checkFrame(16'h0765, 1'b0, "pclo");

        // Seven presses wrap from 6 back to 0
        for (int i = 1; i <= 7; i++) begin
            press(1'b1, 1'b0);
            chk($sformatf("wrap_ledSel%0d", i), {29'd0, ledSel}, i % 7);
        end
        press(1'b0, 1'b1);
        checkFrame(16'h89AB, 1'b1, "pchi");
        press(1'b1, 1'b0);
        chk("alu_ledSel", {29'd0, ledSel}, 32'd1);
        checkFrame(16'hC3E0, 1'b0, "alulo");

        // Simultaneous buttons while half=1: select wins, half clears
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        chk("both_ledSel", {29'd0, ledSel}, 32'd2);
        checkFrame(16'hABCD, 1'b0, "both");

        // Leading zeros on a small value
        aluResult = 32'h0000_000F;
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("rst2_ledSel", {29'd0, ledSel}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        press(1'b1, 1'b0);
        chk("lz_ledSel", {29'd0, ledSel}, 32'd1);
        checkFrame(16'h000F, 1'b0, "lz");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
